// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the wait-state multicycle controller: states, opcode classes,
// ACU sub-ops, ALU ops, jump conditions and the packed control word.
package multicycle_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IF   = 4'd0;
  localparam state_t ST_ID   = 4'd1;
  localparam state_t ST_OPF  = 4'd2;
  localparam state_t ST_J    = 4'd3;
  localparam state_t ST_ACU  = 4'd4;
  localparam state_t ST_LW1  = 4'd5;
  localparam state_t ST_LW2  = 4'd6;
  localparam state_t ST_AM1  = 4'd7;
  localparam state_t ST_AM2  = 4'd8;
  localparam state_t ST_SW   = 4'd9;
  localparam state_t ST_DI   = 4'd10;
  localparam state_t ST_HALT = 4'd11;

  localparam logic [2:0] CLS_LW   = 3'b000;
  localparam logic [2:0] CLS_SW   = 3'b001;
  localparam logic [2:0] CLS_ADDM = 3'b010;
  localparam logic [2:0] CLS_ANDM = 3'b011;
  localparam logic [2:0] CLS_JMP  = 3'b110;
  localparam logic [2:0] CLS_DI   = 3'b111;
  localparam logic [1:0] CLS_ACU_PFX = 2'b10;

  localparam logic [1:0] SUB_MOV = 2'b00;
  localparam logic [1:0] SUB_ADD = 2'b01;
  localparam logic [1:0] SUB_AND = 2'b10;
  localparam logic [1:0] SUB_OR  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] COND_ALW = 2'b00;
  localparam logic [1:0] COND_C   = 2'b01;
  localparam logic [1:0] COND_Z   = 2'b10;
  localparam logic [1:0] COND_N   = 2'b11;

  typedef struct packed {
    logic       sel_a;
    logic       sel_b;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       ir_ld;
    logic       tr_ld;
    logic       mdr_ld;
    logic       di_ld;
    logic       czn_ld;
    logic       reg_write;
    logic       ra2_sel;
    logic       wa_sel;
    logic       wd_sel;
    logic       jmp_signal;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_ws_if.sv
// Controller-to-datapath bundle: IR, flags and memory handshake in, datapath controls out.
interface multicycle_ctrl_ws_if #(
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned STATE_W  = 4
);
  logic [INSTR_W-1:0]  ins;
  logic                flag_c, flag_z, flag_n;
  logic                mem_ready;
  logic                sel_a, sel_b, i_or_d, mem_read, mem_write, pc_write;
  logic                ir_ld, tr_ld, mdr_ld, di_ld, czn_ld, reg_write;
  logic                ra2_sel, wa_sel, wd_sel, jmp_signal;
  logic [ALU_OP_W-1:0] alu_op;
  logic                halted;
  logic [STATE_W-1:0]  state_o;

  modport master (
    input  ins, flag_c, flag_z, flag_n, mem_ready,
    output sel_a, sel_b, i_or_d, mem_read, mem_write, pc_write, ir_ld, tr_ld, mdr_ld,
           di_ld, czn_ld, reg_write, ra2_sel, wa_sel, wd_sel, jmp_signal, alu_op, halted,
           state_o
  );

  modport slave (
    output ins, flag_c, flag_z, flag_n, mem_ready,
    input  sel_a, sel_b, i_or_d, mem_read, mem_write, pc_write, ir_ld, tr_ld, mdr_ld,
           di_ld, czn_ld, reg_write, ra2_sel, wa_sel, wd_sel, jmp_signal, alu_op, halted,
           state_o
  );
endinterface

// File: rtl/multicycle_ctrl_cond.sv
// Jump-condition evaluator; with HAS_COND_JMP=0 every jump is taken.
module multicycle_ctrl_cond
  import multicycle_ctrl_pkg::*;
#(
  parameter bit HAS_COND_JMP = 1'b1
) (
  input  logic [1:0] cond,
  input  logic       flag_c,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       taken
);

  always_comb begin
    taken = 1'b1;
    if (HAS_COND_JMP) begin
      case (cond)
        COND_ALW: taken = 1'b1;
        COND_C:   taken = flag_c;
        COND_Z:   taken = flag_z;
        COND_N:   taken = flag_n;
        default:  taken = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_ws.sv
// Multicycle control FSM with mem_ready wait states, conditional jumps and illegal-op halt.
module multicycle_ctrl_ws
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W      = 8,
  parameter int unsigned ALU_OP_W     = 2,
  parameter bit          HAS_COND_JMP = 1'b1,
  parameter int unsigned STATE_W      = 4
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_ctrl_ws_if.master bus
);

  state_t     state_q, state_d;
  ctrl_t      c, cg;
  logic [2:0] cls;
  logic [1:0] sub;
  logic       illegal;
  logic       taken;

  assign cls = bus.ins[INSTR_W-1 -: 3];
  assign sub = bus.ins[5:4];

  // Only wide instruction words can carry illegal high bits.
  if (INSTR_W > 8) begin : g_wide
    assign illegal = |bus.ins[INSTR_W-1:8];
  end else begin : g_narrow
    assign illegal = 1'b0;
  end

  multicycle_ctrl_cond #(
    .HAS_COND_JMP (HAS_COND_JMP)
  ) u_cond (
    .cond   (bus.ins[INSTR_W-4 -: 2]),
    .flag_c (bus.flag_c),
    .flag_z (bus.flag_z),
    .flag_n (bus.flag_n),
    .taken  (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    c       = '0;
    state_d = state_q;
    case (state_q)
      ST_IF: begin
        c.mem_read = 1'b1;
        if (bus.mem_ready) begin
          c.ir_ld    = 1'b1;
          c.pc_write = 1'b1;
          state_d    = ST_ID;
        end
      end
      ST_ID: begin
        if (illegal)                   state_d = ST_HALT;
        else if (cls[2:1] == CLS_ACU_PFX) state_d = ST_ACU;
        else if (cls == CLS_DI)        state_d = ST_DI;
        else                           state_d = ST_OPF;
      end
      ST_OPF: begin
        c.mem_read = 1'b1;
        if (bus.mem_ready) begin
          c.tr_ld    = 1'b1;
          c.pc_write = 1'b1;
          case (cls)
            CLS_LW:             state_d = ST_LW1;
            CLS_SW:             state_d = ST_SW;
            CLS_ADDM, CLS_ANDM: state_d = ST_AM1;
            CLS_JMP:            state_d = ST_J;
            default:            state_d = ST_IF;
          endcase
        end
      end
      ST_J: begin
        c.jmp_signal = taken;
        c.pc_write   = taken;
        state_d      = ST_IF;
      end
      ST_ACU: begin
        c.sel_b     = 1'b1;
        c.wd_sel    = 1'b1;
        c.reg_write = 1'b1;
        c.czn_ld    = 1'b1;
        case (sub)
          SUB_MOV: begin
            c.sel_a  = 1'b1;
            c.alu_op = ALU_ADD;
          end
          SUB_ADD: c.alu_op = ALU_ADD;
          SUB_AND: c.alu_op = ALU_AND;
          SUB_OR:  c.alu_op = ALU_OR;
          default: c.alu_op = ALU_ADD;
        endcase
        state_d = ST_IF;
      end
      ST_LW1, ST_AM1: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
        if (bus.mem_ready) begin
          c.mdr_ld = 1'b1;
          state_d  = (state_q == ST_LW1) ? ST_LW2 : ST_AM2;
        end
      end
      ST_LW2: begin
        c.ra2_sel   = 1'b1;
        c.wa_sel    = 1'b1;
        c.reg_write = 1'b1;
        state_d     = ST_IF;
      end
      ST_AM2: begin
        c.ra2_sel   = 1'b1;
        c.wa_sel    = 1'b1;
        c.wd_sel    = 1'b1;
        c.reg_write = 1'b1;
        c.czn_ld    = 1'b1;
        c.alu_op    = (cls == CLS_ANDM) ? ALU_AND : ALU_ADD;
        state_d     = ST_IF;
      end
      ST_SW: begin
        c.ra2_sel   = 1'b1;
        c.sel_b     = 1'b1;
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
        if (bus.mem_ready) state_d = ST_IF;
      end
      ST_DI: begin
        c.di_ld = 1'b1;
        state_d = ST_IF;
      end
      ST_HALT: c.halted = 1'b1;
      default: state_d = ST_IF;
    endcase
  end

  // Reset forces every output low, even mid-instruction, so no write escapes.
  assign cg = rst ? '0 : c;

  assign bus.sel_a      = cg.sel_a;
  assign bus.sel_b      = cg.sel_b;
  assign bus.i_or_d     = cg.i_or_d;
  assign bus.mem_read   = cg.mem_read;
  assign bus.mem_write  = cg.mem_write;
  assign bus.pc_write   = cg.pc_write;
  assign bus.ir_ld      = cg.ir_ld;
  assign bus.tr_ld      = cg.tr_ld;
  assign bus.mdr_ld     = cg.mdr_ld;
  assign bus.di_ld      = cg.di_ld;
  assign bus.czn_ld     = cg.czn_ld;
  assign bus.reg_write  = cg.reg_write;
  assign bus.ra2_sel    = cg.ra2_sel;
  assign bus.wa_sel     = cg.wa_sel;
  assign bus.wd_sel     = cg.wd_sel;
  assign bus.jmp_signal = cg.jmp_signal;
  assign bus.alu_op     = ALU_OP_W'(cg.alu_op);
  assign bus.halted     = cg.halted;
  assign bus.state_o    = STATE_W'(rst ? ST_IF : state_q);

endmodule

// File: doc/multicycle_ctrl_ws.md
Name: multicycle_ctrl_ws

Overview:
- Next-generation multicycle control unit for the 8-bit accumulator/register CPU datapath.
- Replaces the fixed single-cycle-memory controller. Memory accesses now use a `mem_ready` wait-state handshake, and the operand fetch is an explicit state.
- Adds flag-conditional jumps and an illegal-opcode halt.
- Sits between the instruction register and the datapath muxes, load enables, register file and memory.

Parameters:
- INSTR_W, 8: instruction width; opcode class is always `ins[INSTR_W-1:INSTR_W-3]`.
- ALU_OP_W, 2: width of `alu_op`.
- HAS_COND_JMP, 1: 1 = JMP honours the condition field `ins[INSTR_W-4:INSTR_W-5]`; 0 = every JMP is taken.
- STATE_W, 4: width of the `state_o` debug port.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ins  in  INSTR_W  current IR contents
- flag_c, flag_z, flag_n  in  1 each  registered CZN flags
- mem_ready  in  1  memory completes the current read or write this cycle
- sel_a, sel_b, i_or_d, mem_read, mem_write, pc_write, ir_ld, tr_ld, mdr_ld, di_ld, czn_ld, reg_write, ra2_sel, wa_sel, wd_sel, jmp_signal  out  1 each  datapath controls
- alu_op  out  ALU_OP_W  00 add/pass, 01 and, 10 or, 11 unused
- halted  out  1  controller is stopped on an illegal opcode
- state_o  out  STATE_W  current state encoding (debug)

Behaviour:
- Opcode classes:
  - 000 LW, 001 SW
  - 010 ADDM, 011 ANDM
  - 10x ACU; sub-op `ins[5:4]`: 00 mov, 01 add, 10 and, 11 or
  - 110 JMP, 111 DI
- Reset: on a clk edge with rst=1, state<=IF and halted<=0. While rst=1, every output is 0, including `alu_op`.
- Outputs are a pure function of registered state, `ins`, flags and `mem_ready`. No latches; every output has a default of 0.
- States and transitions:
  - IF: mem_read=1, i_or_d=0. When mem_ready=1: ir_ld=1, pc_write=1, go to ID; otherwise stay.
  - ID:
    - Classes 000/001/010/011/110 go to OPF.
    - 10x goes to ACU.
    - 111 goes to DI.
    - INSTR_W>8 with nonzero `ins[INSTR_W-1:8]`: illegal, go to HALT.
  - OPF: mem_read=1, i_or_d=0. When mem_ready=1: tr_ld=1, pc_write=1, then branch by class to LW1, SW, AM1 or J; otherwise stay.
  - J: condition code 00 always, 01 C, 10 Z, 11 N. If taken: jmp_signal=1, pc_write=1. If not taken: no outputs. Next state IF.
  - ACU:
    - sel_b=1, wd_sel=1, wa_sel=0, reg_write=1, czn_ld=1.
    - mov: sel_a=1, alu_op=00. add: alu_op=00. and: alu_op=01. or: alu_op=10.
    - Next state IF.
  - LW1: i_or_d=1, mem_read=1; on mem_ready: mdr_ld=1, go to LW2.
  - LW2: ra2_sel=1, wa_sel=1, wd_sel=0, reg_write=1; next state IF.
  - AM1: identical to LW1, but goes to AM2.
  - AM2: ra2_sel=1, wa_sel=1, wd_sel=1, reg_write=1, czn_ld=1; alu_op=00 for 010, 01 for 011; next state IF.
  - SW: ra2_sel=1, sel_b=1, i_or_d=1, mem_write=1 held until mem_ready=1; then go to IF.
  - DI: di_ld=1; next state IF.
  - HALT: halted=1, all other outputs 0; leave only on rst.
- Any unused state encoding goes to IF next cycle with all outputs 0.
- Latency with mem_ready tied to 1:
  - ACU and DI: 3 cycles.
  - JMP: 4 cycles.
  - LW, ADDM/ANDM: 5 cycles.
  - SW: 4 cycles.
- Each extra mem_ready=0 cycle adds exactly one cycle. During wait cycles mem_read/mem_write, i_or_d and ra2_sel/sel_b stay stable, and no load enable pulses.
- Load enables (ir_ld, tr_ld, mdr_ld, pc_write in IF/OPF) assert only in the cycle mem_ready=1.
- rst asserted mid-instruction, including during a wait: returns to IF next edge; no write enable asserts during the rst cycle.
- mem_ready=1 outside a memory state is ignored.

Decomposition:
- Package `multicycle_ctrl_pkg`: state enum, opcode-class constants, ACU sub-op constants, ALU_OP constants, jump-condition constants.
- One sub-module, `multicycle_ctrl_cond`: combinational jump-condition evaluator taking `ins` condition bits, flags and HAS_COND_JMP, producing `taken`.
- The FSM and output decode stay in the top module.

Test Plan:
- rst=1 for 2 cycles, then 0; ins=8'h90 (ACU add), mem_ready=1 → states IF, ID, ACU. In ACU: reg_write=1, czn_ld=1, sel_b=1, alu_op=00. Back in IF at cycle 4.
- ins=8'h00 (LW), mem_ready low for 2 cycles in LW1 → mem_read=1 and i_or_d=1 held for 3 cycles; mdr_ld pulses once in the third; LW2 has reg_write=1, wa_sel=1.
- ins=8'hD0 (JMP cond Z), flag_z=0 → J has jmp_signal=0, pc_write=0. Repeat with flag_z=1 → both 1. HAS_COND_JMP=0 → taken regardless.
- ins=8'h20 (SW), mem_ready low for 1 cycle → mem_write=1 for 2 cycles, ra2_sel=1, sel_b=1; returns to IF.
- ins=8'h60 (ANDM) → AM2 has alu_op=01, czn_ld=1, wd_sel=1. Assert rst during AM1 wait → state IF next cycle, reg_write never asserted.
- INSTR_W=12, `ins[11:8]`=4'h1 → HALT, halted=1; only rst clears it.
